// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, Cause.IP bit offsets, interrupt FSM
// states and reset values for the interrupt/timer unit.
package cp0_pkg;

  localparam logic [7:0] CP0_COUNT_ADDR   = {5'd9, 3'd0};
  localparam logic [7:0] CP0_COMPARE_ADDR = {5'd11, 3'd0};

  localparam int IP_SW_LSB = 0;
  localparam int IP_HW_LSB = 2;

  localparam logic [31:0] COUNT_RESET   = 32'h0000_0000;
  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    REQ     = 3'b010,
    SERVICE = 3'b100
  } int_state_t;

  // Index of the highest set bit; bit 7 has top priority, 0 when nothing is set.
  function automatic logic [2:0] ip_priority(input logic [7:0] p);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/cp0_sync_bus.sv
// Multi-flop synchroniser for a bus of independent asynchronous level signals.
module cp0_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/cp0_int_timer.sv
// CP0 interrupt and Count/Compare timer unit. Define CP0_TIMER_INT_EN to build the
// Count==Compare match logic that drives Cause.TI; otherwise timer_int is tied to 0.
module cp0_int_timer
  import cp0_pkg::*;
#(
  parameter int NUM_HW_INT  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 2,
  parameter int TIMER_LINE  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  commit,
  input  logic [4:0]            wr_addr,
  input  logic [2:0]            wr_sel,
  input  logic [31:0]           data_i,
  input  logic [4:0]            rd_addr,
  input  logic [2:0]            rd_sel,
  output logic [31:0]           data_o,
  output logic                  rd_hit,
  input  logic [NUM_HW_INT-1:0] hw_int_in,
  input  logic [1:0]            sw_int,
  input  logic [7:0]            int_mask,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic                  status_erl,
  input  logic                  int_ack,
  input  logic                  eret,
  output logic                  int_req,
  output logic [2:0]            int_code,
  output logic [7:0]            cause_ip,
  output logic                  timer_int,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output int_state_t            int_state
);

  localparam int PW = 5;

  logic [PW-1:0]         presc;
  logic                  presc_tick;
  logic [7:0]            wr_key;
  logic [7:0]            rd_key;
  logic                  count_wr;
  logic                  compare_wr;
  logic [NUM_HW_INT-1:0] hw_sync;
  logic [5:0]            hw_ip;
  logic [7:0]            ip;
  logic [7:0]            pending;
  logic                  enable;
  int_state_t            state;

  assign wr_key     = {wr_addr, wr_sel};
  assign rd_key     = {rd_addr, rd_sel};
  assign count_wr   = we & commit & (wr_key == CP0_COUNT_ADDR);
  assign compare_wr = we & commit & (wr_key == CP0_COMPARE_ADDR);
  assign presc_tick = (presc == PW'(COUNT_DIV - 1));

  // A committed Count write restarts the prescaler and beats any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o   <= COUNT_RESET;
      compare_o <= COMPARE_RESET;
      presc     <= '0;
    end else begin
      if (count_wr) begin
        count_o <= data_i;
        presc   <= '0;
      end else begin
        presc <= presc_tick ? '0 : presc + 1'b1;
        if (presc_tick) count_o <= count_o + 32'd1;
      end
      if (compare_wr) compare_o <= data_i;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic timer_q;

  // Sticky until Compare is rewritten; the rewrite beats a same-cycle match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 1'b0;
    end else if (compare_wr) begin
      timer_q <= 1'b0;
    end else if (count_o == compare_o) begin
      timer_q <= 1'b1;
    end
  end

  assign timer_int = timer_q;
`else
  assign timer_int = 1'b0;
`endif

  cp0_sync_bus #(
    .WIDTH  (NUM_HW_INT),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int_in),
    .q   (hw_sync)
  );

  always_comb begin
    hw_ip                   = '0;
    hw_ip[NUM_HW_INT-1:0]   = hw_sync;
    ip                      = '0;
    ip[IP_SW_LSB +: 2]      = sw_int;
    ip[IP_HW_LSB +: 6]      = hw_ip;
    ip[TIMER_LINE + IP_HW_LSB] = ip[TIMER_LINE + IP_HW_LSB] | timer_int;
  end

  assign cause_ip = ip;
  assign pending  = ip & int_mask;
  assign enable   = status_ie & ~status_exl & ~status_erl;

  // Handshake: int_req is held while in REQ; a one-cycle int_ack seen in REQ
  // transfers the interrupt (ack beats retraction), and eret in SERVICE re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      int_req  <= 1'b0;
      int_code <= 3'd0;
    end else begin
      int_code <= ip_priority(pending);
      unique case (state)
        IDLE: begin
          if (enable && (pending != 8'd0)) begin
            state   <= REQ;
            int_req <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state   <= SERVICE;
            int_req <= 1'b0;
          end else if (!enable || (pending == 8'd0)) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end
        end
        SERVICE: begin
          int_req <= 1'b0;
          if (eret) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

  assign int_state = state;

  assign rd_hit = (rd_key == CP0_COUNT_ADDR) || (rd_key == CP0_COMPARE_ADDR);
  assign data_o = (rd_key == CP0_COUNT_ADDR)   ? count_o   :
                  (rd_key == CP0_COMPARE_ADDR) ? compare_o : 32'd0;

endmodule

// File: tb/tb_cp0_int_timer.sv
// Bench for cp0_int_timer: directed steps followed by random traffic, all checked
// against a behavioural model; follows CP0_TIMER_INT_EN when it is defined.
module tb_cp0_int_timer;
  import cp0_pkg::*;

  localparam int NHW        = 6;
  localparam int STAGES     = 3;
  localparam int COUNT_DIV  = 2;
  localparam int TIMER_LINE = 5;
`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           we = 1'b0, commit = 1'b0;
  logic [4:0]     wr_addr = '0, rd_addr = '0;
  logic [2:0]     wr_sel = '0, rd_sel = '0;
  logic [31:0]    data_i = '0;
  logic [31:0]    data_o;
  logic           rd_hit;
  logic [NHW-1:0] hw_int_in = '0;
  logic [1:0]     sw_int = '0;
  logic [7:0]     int_mask = '0;
  logic           status_ie = 1'b0, status_exl = 1'b0, status_erl = 1'b0;
  logic           int_ack = 1'b0, eret = 1'b0;
  logic           int_req;
  logic [2:0]     int_code;
  logic [7:0]     cause_ip;
  logic           timer_int;
  logic [31:0]    count_o, compare_o;
  int_state_t     int_state;

  int checks = 0;
  int failures = 0;

  cp0_int_timer #(
    .NUM_HW_INT (NHW), .SYNC_STAGES (STAGES), .COUNT_DIV (COUNT_DIV), .TIMER_LINE (TIMER_LINE)
  ) dut (
    .clk (clk), .rst (rst), .we (we), .commit (commit), .wr_addr (wr_addr), .wr_sel (wr_sel),
    .data_i (data_i), .rd_addr (rd_addr), .rd_sel (rd_sel), .data_o (data_o), .rd_hit (rd_hit),
    .hw_int_in (hw_int_in), .sw_int (sw_int), .int_mask (int_mask), .status_ie (status_ie),
    .status_exl (status_exl), .status_erl (status_erl), .int_ack (int_ack), .eret (eret),
    .int_req (int_req), .int_code (int_code), .cause_ip (cause_ip), .timer_int (timer_int),
    .count_o (count_o), .compare_o (compare_o), .int_state (int_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0]    m_base, m_compare;
  int             m_ticks;
  bit             m_timer, m_req, m_srv;
  logic [2:0]     m_code;
  logic [NHW-1:0] m_sync;
  logic [NHW-1:0] exp_q[$];   // hardware line history, oldest first

  task automatic model_reset();
    m_base = 32'd0; m_ticks = 0; m_compare = 32'hFFFF_FFFF;
    m_timer = 1'b0; m_req = 1'b0; m_srv = 1'b0; m_code = 3'd0; m_sync = '0;
    exp_q.delete();
    for (int i = 0; i < STAGES; i++) exp_q.push_back('0);
  endtask

  function automatic logic [31:0] model_count();
    return m_base + 32'(m_ticks / COUNT_DIV);
  endfunction

  function automatic logic [7:0] exp_cause();
    logic [7:0] c;
    c = {m_sync, sw_int};
    if (m_timer) c[TIMER_LINE + 2] = 1'b1;
    return c;
  endfunction

  function automatic logic [2:0] top_bit(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  // One clock edge: next model state from pre-edge inputs, committed after the edge.
  task automatic tick();
    logic [31:0]    cur, wdata;
    bit             cwc, cwp, en, n_timer, n_req, n_srv;
    logic [7:0]     pend;
    logic [2:0]     n_code;
    logic [NHW-1:0] hw_now;
    cur    = model_count();
    wdata  = data_i;
    hw_now = hw_int_in;
    cwc    = we && commit && wr_addr == 5'd9 && wr_sel == 3'd0;
    cwp    = we && commit && wr_addr == 5'd11 && wr_sel == 3'd0;
    n_timer = TIMER_EN && !cwp && (m_timer || cur == m_compare);
    pend   = exp_cause() & int_mask;
    en     = status_ie && !status_exl && !status_erl;
    n_code = top_bit(pend);
    n_req  = m_req; n_srv = m_srv;
    if (m_srv) begin
      if (eret) n_srv = 1'b0;
    end else if (m_req) begin
      if (int_ack) begin n_req = 1'b0; n_srv = 1'b1; end
      else if (!en || pend == 8'd0) n_req = 1'b0;
    end else if (en && pend != 8'd0) begin
      n_req = 1'b1;
    end
    @(posedge clk); #1;
    if (cwc) begin m_base = wdata; m_ticks = 0; end
    else m_ticks++;
    if (cwp) m_compare = wdata;
    m_timer = n_timer; m_req = n_req; m_srv = n_srv; m_code = n_code;
    exp_q.push_back(hw_now);
    void'(exp_q.pop_front());
    m_sync = exp_q[0];
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit          hit_c, hit_p;
    logic [31:0] rd_exp;
    hit_c  = rd_addr == 5'd9 && rd_sel == 3'd0;
    hit_p  = rd_addr == 5'd11 && rd_sel == 3'd0;
    rd_exp = hit_c ? model_count() : (hit_p ? m_compare : 32'd0);
    chk({tag, ".count"},     count_o,   model_count());
    chk({tag, ".compare"},   compare_o, m_compare);
    chk({tag, ".timer_int"}, 32'(timer_int), 32'(m_timer));
    chk({tag, ".cause_ip"},  32'(cause_ip),  32'(exp_cause()));
    chk({tag, ".int_req"},   32'(int_req),   32'(m_req));
    chk({tag, ".int_code"},  32'(int_code),  32'(m_code));
    chk({tag, ".rd_hit"},    32'(rd_hit),    32'(hit_c || hit_p));
    chk({tag, ".data_o"},    data_o,    rd_exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    tick();
    check_all(tag);
  endtask

  task automatic cp0_write(input logic [4:0] addr, input logic [31:0] val, input logic cmt);
    we = 1'b1; commit = cmt; wr_addr = addr; wr_sel = 3'd0; data_i = val;
    step("write");
    we = 1'b0; commit = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    sw_int = 2'b10; rd_addr = 5'd11;
    #12;
    chk("rst.count",    count_o, 32'd0);
    chk("rst.compare",  compare_o, 32'hFFFF_FFFF);
    chk("rst.int_req",  32'(int_req), 32'd0);
    chk("rst.int_code", 32'(int_code), 32'd0);
    chk("rst.timer",    32'(timer_int), 32'd0);
    chk("rst.cause_ip", 32'(cause_ip), 32'h02);
    chk("rst.data_o",   data_o, 32'hFFFF_FFFF);
    sw_int = 2'b00; rd_addr = 5'd9;
    @(negedge clk) rst = 1'b0;

    // Prescaler
    step("presc"); step("presc");
    chk("presc.count_2", count_o, 32'd1);
    for (int i = 0; i < 8; i++) step("presc");
    chk("presc.count_10", count_o, 32'd5);

    // Uncommitted write is dropped; committed write wraps four cycles later
    cp0_write(5'd9, 32'h1234_0000, 1'b0);
    chk("nocommit.count", count_o, 32'd5);
    cp0_write(5'd9, 32'hFFFF_FFFE, 1'b1);
    chk("cntwr.count", count_o, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) step("wrap");
    chk("wrap.count", count_o, 32'd0);

    // Timer match on IP[7]
    rd_addr = 5'd11;
    cp0_write(5'd11, 32'd20, 1'b1);
    int_mask = 8'h80; status_ie = 1'b1;
    for (int i = 0; i < 60 && count_o != 32'd20; i++) step("timer_run");
    chk("timer.reach20", count_o, 32'd20);
    step("timer");
    chk("timer.set", 32'(timer_int), 32'(TIMER_EN));
    step("timer");
    chk("timer.int_req", 32'(int_req), 32'(TIMER_EN));
    chk("timer.int_code", 32'(int_code), TIMER_EN ? 32'd7 : 32'd0);

    // Handshake: a software bit guarantees a request in every build
    sw_int = 2'b01; int_mask = 8'h81;
    for (int i = 0; i < 4 && int_req !== 1'b1; i++) step("hs_wait");
    chk("hs.req", 32'(int_req), 32'd1);
    int_ack = 1'b1; step("hs_ack"); int_ack = 1'b0;
    chk("hs.ack_req", 32'(int_req), 32'd0);
    chk("hs.state_srv", 32'(int_state), 32'(SERVICE));
    hw_int_in = 6'b000001; int_mask = 8'h85;
    for (int i = 0; i < 5; i++) step("hs_srv");
    chk("hs.held_off", 32'(int_req), 32'd0);
    eret = 1'b1; step("hs_eret"); eret = 1'b0;
    chk("hs.state_idle", 32'(int_state), 32'(IDLE));
    step("hs_rearm");
    chk("hs.rearm", 32'(int_req), 32'd1);

    // Compare write clears the timer bit
    cp0_write(5'd11, 32'h0000_1000, 1'b1);
    chk("cmpwr.timer", 32'(timer_int), 32'd0);
    chk("cmpwr.compare", compare_o, 32'h0000_1000);

    // Retraction, and ack beating retraction
    status_exl = 1'b1; step("retract");
    chk("retract.req", 32'(int_req), 32'd0);
    status_exl = 1'b0; step("retract_re");
    chk("retract.re_req", 32'(int_req), 32'd1);
    int_ack = 1'b1; status_exl = 1'b1; step("ack_wins");
    int_ack = 1'b0; status_exl = 1'b0;
    chk("ack_wins.state", 32'(int_state), 32'(SERVICE));
    eret = 1'b1; step("ack_eret"); eret = 1'b0;

    // Synchroniser latency and priority
    hw_int_in = '0; sw_int = 2'b00; int_mask = 8'h00;
    for (int i = 0; i < 6; i++) step("flush");
    sw_int = 2'b01; int_mask = 8'h11; hw_int_in = 6'b000100;
    step("sync1"); hw_int_in = '0;
    chk("sync.c1", 32'(cause_ip[4]), 32'd0);
    step("sync2");
    chk("sync.c2", 32'(cause_ip[4]), 32'd0);
    step("sync3");
    chk("sync.c3", 32'(cause_ip[4]), 32'd1);
    step("sync4");
    chk("sync.code", 32'(int_code), 32'd4);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) == 0); commit = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: wr_addr = 5'd9;
        1: wr_addr = 5'd11;
        default: wr_addr = 5'($urandom);
      endcase
      wr_sel = 3'($urandom_range(0, 1));
      data_i = model_count() + 32'($urandom_range(0, 8));
      rd_addr = ($urandom_range(0, 1) == 0) ? 5'd9 : (($urandom_range(0, 1) == 0) ? 5'd11 : 5'($urandom));
      rd_sel = 3'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) hw_int_in = NHW'($urandom);
      sw_int = 2'($urandom); int_mask = 8'($urandom);
      status_ie = ($urandom_range(0, 5) != 0);
      status_exl = ($urandom_range(0, 5) == 0);
      status_erl = ($urandom_range(0, 9) == 0);
      int_ack = ($urandom_range(0, 3) == 0); eret = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // Asynchronous reset in the middle of a request
    we = 1'b0; commit = 1'b0; int_ack = 1'b0; rd_addr = 5'd9; rd_sel = 3'd0;
    sw_int = 2'b01; int_mask = 8'h01; status_ie = 1'b1; status_exl = 1'b0; status_erl = 1'b0;
    eret = 1'b1; step("ar_eret"); eret = 1'b0;
    for (int i = 0; i < 4 && int_req !== 1'b1; i++) step("ar_wait");
    chk("arst.pre_req", 32'(int_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.int_req", 32'(int_req), 32'd0);
    chk("arst.count", count_o, 32'd0);
    chk("arst.compare", compare_o, 32'hFFFF_FFFF);
    chk("arst.state", 32'(int_state), 32'(IDLE));
    model_reset();
    @(negedge clk) rst = 1'b0;
    step("post_rst"); step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_int_timer.md
Name: cp0_int_timer

Overview:
Parametrised interrupt and timer unit for the CP0 subsystem. It holds a working Count/Compare timer with a configurable prescaler and synchronises NUM_HW_INT external interrupt lines. It merges the software bits into Cause.IP[7:0] and issues a registered interrupt request to the pipeline's exception stage, with an ack/eret handshake. Cause.IP, Count and Compare are sourced here for the CP0 read mux.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines; range 1..6; drive IP[2+NUM_HW_INT-1:2], upper IP bits read 0
SYNC_STAGES, 2, synchroniser flops per hardware line; range 2..4
COUNT_DIV, 2, clk cycles per Count increment; range 1..16
TIMER_LINE, 5, hardware line index the timer interrupt is ORed onto (IP[TIMER_LINE+2]); must be < 6

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset: asynchronous, active-high
we  in  1  CP0 write enable (mtc0)
commit  in  1  write qualifier; a write takes effect only when we & commit
wr_addr  in  5  write register number
wr_sel  in  3  write select
data_i  in  32  write data
rd_addr  in  5  read register number
rd_sel  in  3  read select
data_o  out  32  read data, combinational
rd_hit  out  1  high when {rd_addr,rd_sel} is Count {9,0} or Compare {11,0}
hw_int_in  in  NUM_HW_INT  asynchronous level interrupt lines
sw_int  in  2  Cause.IP[1:0] from the Cause owner
int_mask  in  8  Status.IM
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
status_erl  in  1  Status.ERL
int_ack  in  1  exception stage took the interrupt (one-cycle pulse)
eret  in  1  eret committed (one-cycle pulse)
int_req  out  1  registered interrupt request
int_code  out  3  index of highest pending IP bit (priority 7 highest)
cause_ip  out  8  IP[7:0] including TI
timer_int  out  1  Cause.TI
count_o  out  32  Count
compare_o  out  32  Compare

Behaviour:
- Reset values: count 0, compare 32'hFFFF_FFFF, prescaler 0, timer_int 0, synchronisers 0, FSM IDLE, int_req 0, int_code 0. cause_ip is therefore {6'b0, sw_int} while rst is high.
- Prescaler: counts 0..COUNT_DIV-1. Count increments by 1 in the cycle the prescaler equals COUNT_DIV-1. Wrap 32'hFFFF_FFFF -> 0 silently.
- Count write ({9,0}, we & commit): loads data_i and clears the prescaler. The write wins over an increment in the same cycle.
- Compare write ({11,0}): loads data_i and clears timer_int next edge.
- Timer match: when count_o == compare_o, timer_int sets at the next edge and stays sticky until a Compare write. A Compare write in the same cycle as a match wins, so timer_int ends 0. Compare value 0 is valid.
- Hardware lines: each passes through SYNC_STAGES flops; assertion-to-IP latency is SYNC_STAGES cycles.
- cause_ip = {hw_sync padded to 6 bits, sw_int}, with IP[TIMER_LINE+2] additionally ORed with timer_int.
- pending = cause_ip & int_mask.
- enable = status_ie & ~status_exl & ~status_erl.
- int_code = priority encode of pending (bit 7 first), registered. It holds 0 when pending = 0.
- FSM, one-hot, 3 states:
  - IDLE: if enable & |pending -> REQ; int_req rises 1 cycle after the condition.
  - REQ: int_req = 1. On int_ack -> SERVICE (ack wins over retraction). Otherwise, if !enable or pending = 0 -> IDLE and int_req drops the next edge.
  - SERVICE: int_req = 0. On eret -> IDLE.
  - int_ack outside REQ and eret outside SERVICE are ignored.
- Read: data_o = count_o or compare_o on rd_hit, else 0. rd_hit = 0 for all other addresses.
- Reset mid-operation: all state returns to reset values asynchronously; no pending request survives.

Optional Feature:
CP0_TIMER_INT_EN
- Defined: timer match logic as above; timer_int drives IP[TIMER_LINE+2].
- Undefined: match logic is removed and timer_int is a constant 0. Count and Compare still count, read and write normally, and a Compare write has no side effect.

Decomposition:
- Package cp0_pkg holds:
  - address constants CP0_COUNT_ADDR {5'd9,3'd0} and CP0_COMPARE_ADDR {5'd11,3'd0}
  - IP bit offsets (IP_SW_LSB = 0, IP_HW_LSB = 2)
  - FSM state typedef int_state_t {IDLE, REQ, SERVICE}
  - COUNT_RESET and COMPARE_RESET constants
- One sub-module, cp0_sync_bus (WIDTH, STAGES): a multi-flop synchroniser with async reset, instantiated once with WIDTH = NUM_HW_INT.

Test Plan:
- Prescaler: COUNT_DIV=2, release reset -> count_o = 1 after 2 cycles, 5 after 10. Write Count = 32'hFFFF_FFFE -> wraps to 0 four cycles later.
- Timer: write Compare = 20, enable int_mask[7], status_ie = 1 -> timer_int = 1 one cycle after count_o = 20. int_req rises next cycle with int_code = 7. A Compare write clears timer_int.
- Handshake: with int_req high, pulse int_ack -> int_req = 0, state SERVICE. Raise hw_int_in[0] with the mask set -> no request until eret, then int_req reasserts 1 cycle after returning to IDLE.
- Retraction: in REQ, set status_exl = 1 with no ack -> int_req drops next edge. If int_ack and status_exl rise in the same cycle -> SERVICE.
- Synchroniser: SYNC_STAGES=3, pulse hw_int_in[2] -> cause_ip[4] high exactly 3 cycles later. Priority check: with sw_int = 2'b01 also pending, int_code = 4.
- Async reset: assert rst mid-REQ without a clk edge -> int_req = 0, count_o = 0, compare_o = 32'hFFFF_FFFF immediately.
